// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants and coordinate types for vga_timing_gen.
// Scroll support in the top is built only when VGA_SCROLL_EN is defined.
package vga_timing_pkg;

    localparam int H_VIS   = 640;
    localparam int H_FP    = 16;
    localparam int H_SYNC  = 96;
    localparam int H_BP    = 48;
    localparam int V_VIS   = 480;
    localparam int V_FP    = 10;
    localparam int V_SYNC  = 2;
    localparam int V_BP    = 33;
    localparam int WORLD_W = 1280;

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    typedef logic [9:0]  coord_t;
    typedef logic [10:0] world_x_t;

    function automatic world_x_t clamp_scroll(input world_x_t s, input int world_w);
        if (int'(s) >= world_w) begin
            return world_x_t'(world_w - 1);
        end
        return s;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter plus sync/visible decodes of the next count,
// so the parent can register coordinates and decodes on the same edge.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int TOTAL      = 800,
    parameter int SYNC_START = 656,
    parameter int SYNC_END   = 752,
    parameter int VIS        = 640
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    output logic [9:0] cnt_d_o,
    output logic       wrap_o,
    output logic       sync_n_o,
    output logic       vis_o
);

    coord_t cnt_q;
    coord_t cnt_d;
    logic   wrap;

    always_comb begin
        wrap  = en_i && (cnt_q == coord_t'(TOTAL - 1));
        cnt_d = cnt_q;
        if (wrap) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_d_o  = cnt_d;
    assign wrap_o   = wrap;
    assign sync_n_o = !((cnt_d >= coord_t'(SYNC_START)) && (cnt_d < coord_t'(SYNC_END)));
    assign vis_o    = (cnt_d < coord_t'(VIS));

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: registered pixel coordinates, blank and syncs.
// Define VGA_SCROLL_EN to add a per-frame horizontal scroll for WorldX.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int P_H_VIS  = H_VIS,
    parameter int P_H_FP   = H_FP,
    parameter int P_H_SYNC = H_SYNC,
    parameter int P_H_BP   = H_BP,
    parameter int P_V_VIS  = V_VIS,
    parameter int P_V_FP   = V_FP,
    parameter int P_V_SYNC = V_SYNC,
    parameter int P_V_BP   = V_BP
) (
    input  logic        vga_clk,
    input  logic        reset_n,
    input  logic [10:0] scroll_x,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic [10:0] WorldX,
    output logic        blank,
    output logic        hs,
    output logic        vs,
    output logic        frame_start
);

    localparam int P_H_TOT = P_H_VIS + P_H_FP + P_H_SYNC + P_H_BP;
    localparam int P_V_TOT = P_V_VIS + P_V_FP + P_V_SYNC + P_V_BP;

    coord_t   h_cnt_d, v_cnt_d;
    logic     h_wrap, v_wrap;
    logic     h_sync_n, v_sync_n, h_vis, v_vis;
    logic     fs_d;
    world_x_t world_d;

    coord_t   draw_x_q, draw_y_q;
    world_x_t world_x_q;
    logic     blank_q, hs_q, vs_q, fs_q;

    vga_axis_counter #(
        .TOTAL      (P_H_TOT),
        .SYNC_START (P_H_VIS + P_H_FP),
        .SYNC_END   (P_H_VIS + P_H_FP + P_H_SYNC),
        .VIS        (P_H_VIS)
    ) u_h_axis (
        .clk      (vga_clk),
        .rst_n    (reset_n),
        .en_i     (1'b1),
        .cnt_d_o  (h_cnt_d),
        .wrap_o   (h_wrap),
        .sync_n_o (h_sync_n),
        .vis_o    (h_vis)
    );

    vga_axis_counter #(
        .TOTAL      (P_V_TOT),
        .SYNC_START (P_V_VIS + P_V_FP),
        .SYNC_END   (P_V_VIS + P_V_FP + P_V_SYNC),
        .VIS        (P_V_VIS)
    ) u_v_axis (
        .clk      (vga_clk),
        .rst_n    (reset_n),
        .en_i     (h_wrap),
        .cnt_d_o  (v_cnt_d),
        .wrap_o   (v_wrap),
        .sync_n_o (v_sync_n),
        .vis_o    (v_vis)
    );

    // Vertical wrap only fires on the last pixel of the frame, so the next pixel is (0,0).
    assign fs_d = v_wrap;

`ifdef VGA_SCROLL_EN
    world_x_t    scroll_q, scroll_d;
    logic [11:0] world_sum;

    // Sum is 12 bits wide: 799 + 1279 does not fit in 11.
    always_comb begin
        scroll_d  = fs_d ? clamp_scroll(scroll_x, WORLD_W) : scroll_q;
        world_sum = {2'b00, h_cnt_d} + {1'b0, scroll_d};
        world_d   = (world_sum >= 12'(WORLD_W)) ? world_x_t'(world_sum - 12'(WORLD_W))
                                                : world_sum[10:0];
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            scroll_q <= '0;
        end else begin
            scroll_q <= scroll_d;
        end
    end
`else
    logic unused_scroll;
    assign unused_scroll = ^scroll_x;
    assign world_d       = {1'b0, h_cnt_d};
`endif

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            draw_x_q  <= '0;
            draw_y_q  <= '0;
            world_x_q <= '0;
            blank_q   <= 1'b0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            fs_q      <= 1'b0;
        end else begin
            draw_x_q  <= h_cnt_d;
            draw_y_q  <= v_cnt_d;
            world_x_q <= world_d;
            blank_q   <= h_vis && v_vis;
            hs_q      <= h_sync_n;
            vs_q      <= v_sync_n;
            fs_q      <= fs_d;
        end
    end

    assign DrawX       = draw_x_q;
    assign DrawY       = draw_y_q;
    assign WorldX      = world_x_q;
    assign blank       = blank_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign frame_start = fs_q;

endmodule
